// File: rtl/exmem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register: widths,
// branch encodings, the ex->mem payload struct and the branch-resolve helper.
package exmem_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQZ  = 2'b01,
    BR_NEZ  = 2'b10,
    BR_JMP  = 2'b11
  } branch_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } exmem_payload_t;

  function automatic logic branch_taken(input logic [1:0] br, input logic zero);
    logic taken;
    case (branch_e'(br))
      BR_EQZ:  taken = zero;
      BR_NEZ:  taken = !zero;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/exmem_entry_reg.sv
// One pipeline entry: a payload register with load enable plus its valid bit.
module exmem_entry_reg
  import exmem_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           valid_d,
  input  exmem_payload_t d,
  output exmem_payload_t q,
  output logic           valid
);

  // NOTE: the payload is reset as well, so held outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      valid <= valid_d;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect and saturating taken counter.
// Define EXMEM_SKID_EN to add a second (skid) entry and a registered ex_ready.
module ex_mem_stage
  import exmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd,
  input  logic              ctl_regwrite,
  input  logic              ctl_memread,
  input  logic              ctl_memwrite,
  input  logic [1:0]        ctl_branch,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  taken_count
);

  exmem_payload_t in_payload;
  exmem_payload_t main_d;
  exmem_payload_t main_q;
  logic           main_valid;
  logic           main_valid_d;
  logic           main_load;
  logic           main_from_skid;
  logic           skid_valid;
  logic           ex_fire;
  logic           mem_fire;
  logic           ex_taken;

  assign in_payload = '{result:     alu_result,
                        store_data: store_data,
                        rd:         rd,
                        regwrite:   ctl_regwrite,
                        memread:    ctl_memread,
                        memwrite:   ctl_memwrite};

  assign ex_fire  = ex_valid & ex_ready & !flush;
  assign mem_fire = main_valid & mem_ready;

  // Main loads when it is empty or draining; the skid (if any) has priority.
  assign main_from_skid = mem_fire & skid_valid;
  assign main_load      = main_from_skid | (ex_fire & (!main_valid | mem_fire));

`ifdef EXMEM_SKID_EN
  exmem_payload_t skid_q;
  logic           skid_valid_d;
  logic           skid_load;

  // An accept while main is stalled parks in skid; ex_ready is a pure flop output.
  assign skid_load = ex_fire & main_valid & !mem_fire;
  assign main_d    = main_from_skid ? skid_q : in_payload;
  assign ex_ready  = !skid_valid;

  always_comb begin
    skid_valid_d = skid_valid;
    if (flush)               skid_valid_d = 1'b0;
    else if (skid_load)      skid_valid_d = 1'b1;
    else if (main_from_skid) skid_valid_d = 1'b0;
  end

  exmem_entry_reg u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .valid_d (skid_valid_d),
    .d       (in_payload),
    .q       (skid_q),
    .valid   (skid_valid)
  );
`else
  assign skid_valid = 1'b0;
  assign main_d     = in_payload;
  assign ex_ready   = !main_valid | mem_ready;
`endif

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    main_valid_d = main_valid;
    if (flush)          main_valid_d = 1'b0;
    else if (main_load) main_valid_d = 1'b1;
    else if (mem_fire)  main_valid_d = 1'b0;
  end

  exmem_entry_reg u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .valid_d (main_valid_d),
    .d       (main_d),
    .q       (main_q),
    .valid   (main_valid)
  );

  assign mem_valid      = main_valid;
  assign mem_alu_result = main_q.result;
  assign mem_store_data = main_q.store_data;
  assign mem_rd         = main_q.rd;
  assign mem_regwrite   = main_q.regwrite;
  assign mem_memread    = main_q.memread;
  assign mem_memwrite   = main_q.memwrite;

  // ex_fire already excludes flush, so a flushed branch never redirects.
  assign ex_taken = ex_fire & branch_taken(ctl_branch, alu_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      taken_count    <= '0;
    end else begin
      redirect_valid <= ex_taken;
      if (ex_taken) begin
        redirect_pc <= branch_target;
        if (taken_count != {CNT_W{1'b1}}) taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage with a payload scoreboard and
// an independent model of ex_ready, redirect and the taken counter.
module tb_ex_mem_stage;
  import exmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic [15:0] store_data;
  logic [3:0]  rd;
  logic        ctl_regwrite;
  logic        ctl_memread;
  logic        ctl_memwrite;
  logic [1:0]  ctl_branch;
  logic [15:0] branch_target;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [15:0] mem_alu_result;
  logic [15:0] mem_store_data;
  logic [3:0]  mem_rd;
  logic        mem_regwrite;
  logic        mem_memread;
  logic        mem_memwrite;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] taken_count;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .store_data     (store_data),
    .rd             (rd),
    .ctl_regwrite   (ctl_regwrite),
    .ctl_memread    (ctl_memread),
    .ctl_memwrite   (ctl_memwrite),
    .ctl_branch     (ctl_branch),
    .branch_target  (branch_target),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_alu_result (mem_alu_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_regwrite   (mem_regwrite),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .taken_count    (taken_count)
  );

  exmem_payload_t sb[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  bit             exp_redir = 1'b0;
  logic [15:0]    exp_pc = '0;
  logic [15:0]    exp_cnt = '0;
  bit             last_fire = 1'b0;

`ifdef EXMEM_SKID_EN
  localparam int STALL_ACCEPTS = 2;
`else
  localparam int STALL_ACCEPTS = 1;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_taken(input logic [1:0] br, input logic z);
    return (br == 2'b11) || (br == 2'b01 && z) || (br == 2'b10 && !z);
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; alu_result = '0; alu_zero = 1'b0; store_data = '0; rd = '0;
    ctl_regwrite = 1'b0; ctl_memread = 1'b0; ctl_memwrite = 1'b0;
    ctl_branch = 2'b00; branch_target = '0; flush = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic set_instr(input exmem_payload_t p, input logic [1:0] br,
                           input logic z, input logic [15:0] tgt);
    alu_result = p.result; store_data = p.store_data; rd = p.rd;
    ctl_regwrite = p.regwrite; ctl_memread = p.memread; ctl_memwrite = p.memwrite;
    ctl_branch = br; alu_zero = z; branch_target = tgt;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_valid", mem_valid, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_taken_count", taken_count, 0);
    check("rst_payload", {mem_alu_result, mem_store_data, mem_rd,
                          mem_regwrite, mem_memread, mem_memwrite}, 0);
  endtask

  // Called at a falling edge with inputs already set; evaluates, then waits one cycle.
  task automatic step();
    logic           exp_rdy;
    bit             fire_mem;
    exmem_payload_t got;
    #1;
    check("mem_valid", mem_valid, (sb.size() != 0));
`ifdef EXMEM_SKID_EN
    exp_rdy = (sb.size() < 2);
`else
    exp_rdy = (sb.size() == 0) || mem_ready;
`endif
    check("ex_ready", ex_ready, exp_rdy);
    check("redirect_valid", redirect_valid, exp_redir);
    if (exp_redir) check("redirect_pc", redirect_pc, exp_pc);
    check("taken_count", taken_count, exp_cnt);
    if (sb.size() != 0) begin
      got = '{mem_alu_result, mem_store_data, mem_rd, mem_regwrite, mem_memread, mem_memwrite};
      check("payload", got, sb[0]);
    end
    fire_mem  = (sb.size() != 0) && mem_ready;
    last_fire = ex_valid && exp_rdy && !flush;
    if (fire_mem) void'(sb.pop_front());
    if (flush) sb.delete();
    if (last_fire)
      sb.push_back('{alu_result, store_data, rd, ctl_regwrite, ctl_memread, ctl_memwrite});
    exp_redir = last_fire && model_taken(ctl_branch, alu_zero);
    if (exp_redir) begin
      exp_pc = branch_target;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic send();
    ex_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_fire) break;
    end
    check("accept_timeout", last_fire, 1);
    ex_valid = 1'b0;
  endtask

  task automatic drain();
    ex_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    step();
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    exmem_payload_t prog[4];
    int             accepts;
    int             idx;
    logic [15:0]    cnt_before;

    prog[0] = '{16'hA001, 16'h1111, 4'd1, 1'b1, 1'b0, 1'b0};
    prog[1] = '{16'hB002, 16'h2222, 4'd2, 1'b0, 1'b1, 1'b0};
    prog[2] = '{16'hC003, 16'h3333, 4'd5, 1'b0, 1'b0, 1'b1};
    prog[3] = '{16'hD004, 16'h4444, 4'd9, 1'b1, 1'b1, 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Plain ALU instruction flows through with one cycle of latency.
    set_instr('{16'h1234, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b0}, 2'b00, 1'b0, 16'h0000);
    send();
    check("alu_mem_valid", mem_valid, 1);
    check("alu_result", mem_alu_result, 16'h1234);
    check("alu_rd", mem_rd, 4'd3);
    check("alu_no_redirect", redirect_valid, 0);
    drain();

    // Branch-if-zero taken, then not taken.
    set_instr('{16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0}, 2'b01, 1'b1, 16'h0040);
    send();
    check("beqz_redirect", redirect_valid, 1);
    check("beqz_pc", redirect_pc, 16'h0040);
    check("beqz_count", taken_count, 16'd1);
    step();
    check("beqz_pulse_end", redirect_valid, 0);
    set_instr('{16'h0005, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0}, 2'b01, 1'b0, 16'h0080);
    send();
    check("beqz_nt_redirect", redirect_valid, 0);
    check("beqz_nt_count", taken_count, 16'd1);
    // Branch-if-nonzero taken.
    set_instr('{16'h0005, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0}, 2'b10, 1'b0, 16'h00C0);
    send();
    check("bnez_pc", redirect_pc, 16'h00C0);
    drain();

    // Four back-to-back instructions against three stalled cycles.
    mem_ready = 1'b0;
    accepts = 0;
    idx = 0;
    set_instr(prog[0], 2'b00, 1'b0, 16'h0000);
    ex_valid = 1'b1;
    repeat (3) begin
      step();
      if (last_fire) begin
        accepts++;
        idx++;
        set_instr(prog[idx], 2'b00, 1'b0, 16'h0000);
      end
    end
    check("stall_accepts", accepts, STALL_ACCEPTS);
    mem_ready = 1'b1;
    for (int i = 0; i < 50 && idx < 4; i++) begin
      step();
      if (last_fire) begin
        idx++;
        if (idx < 4) set_instr(prog[idx], 2'b00, 1'b0, 16'h0000);
      end
    end
    ex_valid = 1'b0;
    check("stall_all_sent", idx, 4);
    drain();

    // Flush in the same cycle as a taken jump while an entry is held.
    mem_ready = 1'b0;
    set_instr(prog[2], 2'b00, 1'b0, 16'h0000);
    send();
    cnt_before = exp_cnt;
    set_instr(prog[3], 2'b11, 1'b0, 16'h0100);
    ex_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    ex_valid = 1'b0;
    check("flush_mem_valid", mem_valid, 0);
    check("flush_no_redirect", redirect_valid, 0);
    check("flush_count", taken_count, cnt_before);
    drain();

    // Saturate the taken counter with unconditional jumps.
    set_instr('{16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0}, 2'b11, 1'b0, 16'h0BEE);
    ex_valid = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    ex_valid = 1'b0;
    step();
    check("sat_count", taken_count, 16'hFFFF);
    drain();

    // Asynchronous reset while entries are held.
    mem_ready = 1'b0;
    set_instr(prog[0], 2'b00, 1'b0, 16'h0000);
    ex_valid = 1'b1;
    step();
    set_instr(prog[1], 2'b00, 1'b0, 16'h0000);
    step();
    ex_valid = 1'b0;
    check("pre_reset_valid", mem_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    exp_redir = 1'b0;
    exp_pc = '0;
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    set_instr(prog[2], 2'b00, 1'b0, 16'h0000);
    send();
    check("post_reset_result", mem_alu_result, 16'hC003);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register between the 16-bit ALU and the memory stage. It captures the ALU result, zero flag and decoded control for one instruction per cycle using a valid/ready handshake. It resolves conditional branches from the zero flag and issues a one-cycle PC redirect. It also keeps a saturating count of taken branches.

## Interface
- DATA_W, 16, datapath width (ALU result, store data, branch target)
- REG_W, 4, destination register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  upstream holds a valid instruction
- ex_ready  out  1  stage can accept this cycle
- alu_result  in  DATA_W  ALU output
- alu_zero  in  1  ALU zero flag
- store_data  in  DATA_W  register value for stores
- rd  in  REG_W  destination register
- ctl_regwrite, ctl_memread, ctl_memwrite  in  1 each  decoded control
- ctl_branch  in  2  00 none, 01 branch-if-zero, 10 branch-if-nonzero, 11 unconditional jump
- branch_target  in  DATA_W  precomputed target PC
- flush  in  1  kill all held entries
- mem_valid  out  1  output entry valid
- mem_ready  in  1  memory stage accepts
- mem_alu_result, mem_store_data  out  DATA_W  held payload
- mem_rd  out  REG_W; mem_regwrite, mem_memread, mem_memwrite  out  1 each
- redirect_valid  out  1  one-cycle pulse, branch taken
- redirect_pc  out  DATA_W  target for the pulse
- taken_count  out  16  saturating taken-branch counter

## Operation
- ex_fire = ex_valid & ex_ready & !flush; mem_fire = mem_valid & mem_ready.
- Taken = (ctl_branch==01 & alu_zero) | (ctl_branch==10 & !alu_zero) | (ctl_branch==11). Taken is evaluated only on ex_fire.
- On a taken ex_fire, the next cycle has redirect_valid=1 and redirect_pc=branch_target for exactly one cycle, and taken_count increments, saturating at 0xFFFF.
- A branch entry still travels to the memory stage with its decoded controls unchanged. Decode drives regwrite=0 for branches.
- Wrong-path squash belongs to upstream. This stage does not drop instructions after a redirect.
- flush clears every valid bit on the next edge and suppresses any redirect from the same cycle. flush does not clear taken_count.
- Simultaneous ex_fire and mem_fire with a single entry: the old entry leaves and the new one loads. No bubble.
- Payload registers hold their value while mem_valid=1 and mem_ready=0. The payload is stable under backpressure.

## Timing
- Reset (async, rst_n low): mem_valid=0, redirect_valid=0, redirect_pc=0, taken_count=0, all payload and control outputs 0, skid empty.
- Latency from ex_fire to mem_valid is 1 cycle. Latency from ex_fire to redirect_valid is 1 cycle.
- Throughput is 1 instruction per cycle when mem_ready is held high.
- Without skid: ex_ready = !mem_valid | mem_ready (combinational path from mem_ready).
- With skid: ex_ready = !skid_valid (registered). No combinational path exists from mem_ready to ex_ready.
- Reset asserted mid-operation discards all entries immediately, and outputs take their reset values asynchronously.

## Configuration
- EXMEM_SKID_EN defined: a second entry (skid) is added. An instruction accepted while the main entry is stalled goes to skid. When the main entry drains, skid moves to main the same cycle. Maximum occupancy is 2, and order is preserved.
- EXMEM_SKID_EN undefined: a single entry with combinational ex_ready as given above.
- Redirect and counter behaviour is identical in both builds.

## Structure
- A shared package holds:
  - DATA_W and REG_W defaults.
  - The branch encoding constants BR_NONE=2'b00, BR_EQZ=2'b01, BR_NEZ=2'b10, BR_JMP=2'b11.
  - A packed struct for the ex→mem payload: result, store data, rd, three control bits.
- One sub-module, exmem_entry_reg: a payload register with load enable and valid bit. It is instantiated once, or twice under EXMEM_SKID_EN.

## Test plan
- Reset release, then ex_valid with alu_result=0x1234, rd=3, regwrite=1, mem_ready=1 -> next cycle mem_valid=1, mem_alu_result=0x1234, mem_rd=3; redirect_valid stays 0.
- ctl_branch=01, alu_zero=1, branch_target=0x0040 -> one-cycle redirect_valid with redirect_pc=0x0040, taken_count=1. Same stimulus with alu_zero=0 -> no redirect, count unchanged.
- mem_ready=0 for 3 cycles with 4 back-to-back instructions -> no-skid build accepts 1, skid build accepts 2. Payload is stable while stalled, and output order is preserved after release.
- flush asserted in the same cycle as a taken-branch ex_fire -> mem_valid=0 next cycle, no redirect, taken_count unchanged.
- 65,536 taken jumps (ctl_branch=11) -> taken_count saturates at 0xFFFF and stays there.
- rst_n pulsed low mid-stall with 2 entries held -> all valids drop immediately, and the first accept after reset yields a fresh entry.
